// File: rtl/ofdm_sync_pkg.sv
// Shared definitions for the OFDM receiver sync blocks: the sync FSM state
// encoding, correlator datapath widths and a small magnitude helper.
package ofdm_sync_pkg;

  localparam int SUM_W = 21;
  localparam int MAG_W = SUM_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_TRACK  = 3'd2,
    ST_ALIGN  = 3'd3,
    ST_DONE   = 3'd4
  } sync_state_e;

  function automatic logic [MAG_W-1:0] mag_max(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sts_peak_mag.sv
// First pipeline stage of the STS sync path: |R| + |I| of the correlator sum,
// registered together with its valid bit. The absolute values are kept
// unsigned so the most negative input maps to 2^(SUM_W-1) exactly.
module sts_peak_mag
  import ofdm_sync_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] sum_r,
  input  logic [SUM_W-1:0] sum_i,
  output logic             mag_valid,
  output logic [MAG_W-1:0] mag
);

  localparam logic [SUM_W-1:0] SUM_ONE = 1;

  logic [SUM_W-1:0] abs_r;
  logic [SUM_W-1:0] abs_i;
  logic [MAG_W-1:0] mag_d;
  logic [MAG_W-1:0] mag_q;
  logic             valid_d;
  logic             valid_q;

  // Two's complement negate on a set sign bit, then widen by one bit and add.
  always_comb begin
    abs_r   = sum_r[SUM_W-1] ? (~sum_r + SUM_ONE) : sum_r;
    abs_i   = sum_i[SUM_W-1] ? (~sum_i + SUM_ONE) : sum_i;
    mag_d   = {1'b0, abs_r} + {1'b0, abs_i};
    valid_d = in_valid;
  end

  // Stage-1 register for the magnitude and its valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      valid_q <= valid_d;
    end
  end

  assign mag       = mag_q;
  assign mag_valid = valid_q;

endmodule

// File: rtl/sts_sync_controller.sv
// STS synchronisation controller: gates the correlator, qualifies periodic
// correlation peaks against a threshold, declares lock and emits a one-cycle
// strobe at the start of the first LTS symbol. Only valid samples advance the
// spacing and timeout counters.
module sts_sync_controller
  import ofdm_sync_pkg::*;
#(
  parameter int STS_LEN      = 16,
  parameter int PEAK_TOL     = 1,
  parameter int PEAK_NUM     = 8,
  parameter int ALIGN_OFFSET = 32,
  parameter int TIMEOUT      = 4096,
  parameter int CNT_W        = 13
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Arm,
  input  logic             Clear,
  input  logic [MAG_W-1:0] Threshold,
  input  logic             CorrelationEnable,
  input  logic [SUM_W-1:0] CorrelationSumR,
  input  logic [SUM_W-1:0] CorrelationSumI,
  output logic             CorrRun,
  output logic             Detected,
  output logic             SymStart,
  output logic [3:0]       PeakCount,
  output logic [MAG_W-1:0] PeakMag,
  output logic             Timeout,
  output logic [2:0]       State
);

  localparam logic [CNT_W-1:0] CNT_ONE    = 1;
  localparam logic [CNT_W-1:0] WIN_LO     = CNT_W'(STS_LEN - PEAK_TOL);
  localparam logic [CNT_W-1:0] WIN_HI     = CNT_W'(STS_LEN + PEAK_TOL);
  localparam logic [CNT_W-1:0] ALIGN_AT   = CNT_W'(ALIGN_OFFSET);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_AT    = 4'(PEAK_NUM);
  localparam logic [3:0]       COUNT_MAX  = 4'hF;

  logic             mag_valid;
  logic [MAG_W-1:0] mag;

  sync_state_e      state_q, state_d;
  logic [MAG_W-1:0] threshold_q, threshold_d;
  logic [3:0]       peak_count_q, peak_count_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
  logic [CNT_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             detected_q, detected_d;
  logic             timeout_q, timeout_d;
  logic             sym_start_q, sym_start_d;
  logic             corr_run_q, corr_run_d;

  logic             is_peak;
  logic             in_window;
  logic             lock_hit;
  logic [CNT_W-1:0] sp_inc;
  logic [CNT_W-1:0] to_inc;
  logic [3:0]       peak_inc;

  sts_peak_mag u_peak_mag (
    .clk       (Clk),
    .rst       (Rst),
    .in_valid  (CorrelationEnable),
    .sum_r     (CorrelationSumR),
    .sum_i     (CorrelationSumI),
    .mag_valid (mag_valid),
    .mag       (mag)
  );

  // Next-state logic: Arm beats Clear, Clear beats the normal sequencing.
  always_comb begin
    state_d      = state_q;
    threshold_d  = threshold_q;
    peak_count_d = peak_count_q;
    peak_mag_d   = peak_mag_q;
    sp_d         = sp_q;
    to_cnt_d     = to_cnt_q;
    detected_d   = detected_q;
    timeout_d    = timeout_q;
    sym_start_d  = 1'b0;

    is_peak   = mag_valid && (mag > threshold_q);
    sp_inc    = sp_q + CNT_ONE;
    to_inc    = to_cnt_q + CNT_ONE;
    peak_inc  = peak_count_q + 4'd1;
    in_window = (sp_inc >= WIN_LO) && (sp_inc <= WIN_HI);
    lock_hit  = is_peak && in_window && (peak_inc == LOCK_AT);

    if (Arm) begin
      state_d      = ST_SEARCH;
      threshold_d  = Threshold;
      peak_count_d = '0;
      peak_mag_d   = '0;
      sp_d         = '0;
      to_cnt_d     = '0;
      detected_d   = 1'b0;
      timeout_d    = 1'b0;
    end else if (Clear) begin
      state_d    = ST_IDLE;
      detected_d = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
        end
        ST_SEARCH: begin
          if (mag_valid) begin
            to_cnt_d = to_inc;
            if (is_peak) begin
              state_d      = ST_TRACK;
              peak_count_d = 4'd1;
              peak_mag_d   = mag;
              sp_d         = '0;
            end
            if (to_inc == TIMEOUT_AT) begin
              timeout_d = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end
        ST_TRACK: begin
          if (mag_valid) begin
            to_cnt_d = to_inc;
            sp_d     = sp_inc;
            if (is_peak && in_window) begin
              peak_count_d = peak_inc;
              peak_mag_d   = mag_max(peak_mag_q, mag);
              sp_d         = '0;
              if (peak_inc == LOCK_AT) begin
                state_d    = ST_ALIGN;
                detected_d = 1'b1;
              end
            end else if (sp_inc >= WIN_HI) begin
              state_d      = ST_SEARCH;
              peak_count_d = '0;
              sp_d         = '0;
            end
            if ((to_inc == TIMEOUT_AT) && !lock_hit) begin
              timeout_d = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end
        ST_ALIGN: begin
          if (mag_valid) begin
            sp_d = sp_inc;
            if (is_peak && in_window) begin
              peak_count_d = (peak_count_q == COUNT_MAX) ? COUNT_MAX : peak_inc;
              peak_mag_d   = mag_max(peak_mag_q, mag);
              sp_d         = '0;
            end else if (sp_inc == ALIGN_AT) begin
              sym_start_d = 1'b1;
              state_d     = ST_DONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    corr_run_d = (state_d == ST_SEARCH) || (state_d == ST_TRACK) ||
                 (state_d == ST_ALIGN);
  end

  // FSM, counter and output registers; everything clears on reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      threshold_q  <= '0;
      peak_count_q <= '0;
      peak_mag_q   <= '0;
      sp_q         <= '0;
      to_cnt_q     <= '0;
      detected_q   <= 1'b0;
      timeout_q    <= 1'b0;
      sym_start_q  <= 1'b0;
      corr_run_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      threshold_q  <= threshold_d;
      peak_count_q <= peak_count_d;
      peak_mag_q   <= peak_mag_d;
      sp_q         <= sp_d;
      to_cnt_q     <= to_cnt_d;
      detected_q   <= detected_d;
      timeout_q    <= timeout_d;
      sym_start_q  <= sym_start_d;
      corr_run_q   <= corr_run_d;
    end
  end

  assign CorrRun   = corr_run_q;
  assign Detected  = detected_q;
  assign SymStart  = sym_start_q;
  assign PeakCount = peak_count_q;
  assign PeakMag   = peak_mag_q;
  assign Timeout   = timeout_q;
  assign State     = state_q;

endmodule

// File: tb/tb_sts_sync_controller.sv
// Bench for the STS sync controller. Each driven correlator sample may push
// expected output values into a scoreboard queue, tagged with the cycle on
// which they must appear (two clocks after the sample).
module tb_sts_sync_controller;
  import ofdm_sync_pkg::*;

  localparam int SEL_DET   = 0;
  localparam int SEL_SYM   = 1;
  localparam int SEL_CNT   = 2;
  localparam int SEL_MAG   = 3;
  localparam int SEL_TO    = 4;
  localparam int SEL_RUN   = 5;
  localparam int SEL_STATE = 6;

  localparam int S_IDLE   = 0;
  localparam int S_SEARCH = 1;
  localparam int S_TRACK  = 2;
  localparam int S_ALIGN  = 3;
  localparam int S_DONE   = 4;

  typedef struct {
    int    due;
    int    sel;
    int    val;
    string tag;
  } sb_item_t;

  logic             clk;
  logic             rst;
  logic             arm;
  logic             clear;
  logic [MAG_W-1:0] threshold;
  logic             corr_en;
  logic [SUM_W-1:0] sum_r;
  logic [SUM_W-1:0] sum_i;
  logic             corr_run;
  logic             detected;
  logic             sym_start;
  logic [3:0]       peak_count;
  logic [MAG_W-1:0] peak_mag;
  logic             timeout_flag;
  logic [2:0]       state_dbg;

  int       cyc = 0;
  int       gap = 0;
  int       tests_run = 0;
  int       failures = 0;
  sb_item_t sb_q[$];

  sts_sync_controller dut (
    .Clk               (clk),
    .Rst               (rst),
    .Arm               (arm),
    .Clear             (clear),
    .Threshold         (threshold),
    .CorrelationEnable (corr_en),
    .CorrelationSumR   (sum_r),
    .CorrelationSumI   (sum_i),
    .CorrRun           (corr_run),
    .Detected          (detected),
    .SymStart          (sym_start),
    .PeakCount         (peak_count),
    .PeakMag           (peak_mag),
    .Timeout           (timeout_flag),
    .State             (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used to time scoreboard entries.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int observe(input int sel);
    case (sel)
      SEL_DET:   return int'(detected);
      SEL_SYM:   return int'(sym_start);
      SEL_CNT:   return int'(peak_count);
      SEL_MAG:   return int'(peak_mag);
      SEL_TO:    return int'(timeout_flag);
      SEL_RUN:   return int'(corr_run);
      SEL_STATE: return int'(state_dbg);
      default:   return -1;
    endcase
  endfunction

  // Compare every scoreboard entry that has come due, away from the rising edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_item_t item;
      item = sb_q.pop_front();
      checkOutput(item.tag, observe(item.sel), item.val);
    end
  end

  task automatic sb_push(input int sel, input int val, input string tag);
    sb_item_t item;
    item.due = cyc + 2;
    item.sel = sel;
    item.val = val;
    item.tag = tag;
    sb_q.push_back(item);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      corr_en = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [SUM_W-1:0] r, input logic [SUM_W-1:0] i);
    if (gap > 0) idle(gap);
    @(posedge clk); #1;
    corr_en = 1'b1;
    sum_r   = r;
    sum_i   = i;
  endtask

  task automatic send_mag(input int m);
    int part;
    part = m / 3;
    applyStimulus(SUM_W'(m - part), SUM_W'(-part));
  endtask

  task automatic arm_run(input int thr);
    idle(2);
    @(posedge clk); #1;
    arm       = 1'b1;
    threshold = MAG_W'(thr);
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_state"}, int'(state_dbg), S_IDLE);
    checkOutput({tag, "_det"}, int'(detected), 0);
    checkOutput({tag, "_sym"}, int'(sym_start), 0);
    checkOutput({tag, "_cnt"}, int'(peak_count), 0);
    checkOutput({tag, "_mag"}, int'(peak_mag), 0);
    checkOutput({tag, "_to"}, int'(timeout_flag), 0);
    checkOutput({tag, "_run"}, int'(corr_run), 0);
  endtask

  // Ten peaks every 16 valid samples, a larger fifth peak, then 33 background samples.
  task automatic run_lock_test(input string pfx);
    arm_run(1000);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) repeat (15) send_mag(100);
      send_mag((k == 5) ? 3000 : 2000);
      sb_push(SEL_CNT, k, $sformatf("%s_p%0d_cnt", pfx, k));
      sb_push(SEL_DET, (k >= 8) ? 1 : 0, $sformatf("%s_p%0d_det", pfx, k));
      sb_push(SEL_STATE, (k >= 8) ? S_ALIGN : S_TRACK, $sformatf("%s_p%0d_state", pfx, k));
      sb_push(SEL_MAG, (k >= 5) ? 3000 : 2000, $sformatf("%s_p%0d_mag", pfx, k));
    end
    for (int n = 1; n <= 33; n++) begin
      send_mag(100);
      if (n == 31) begin
        sb_push(SEL_SYM, 0, {pfx, "_s31_sym"});
        sb_push(SEL_STATE, S_ALIGN, {pfx, "_s31_state"});
        sb_push(SEL_RUN, 1, {pfx, "_s31_run"});
      end
      if (n == 32) begin
        sb_push(SEL_SYM, 1, {pfx, "_s32_sym"});
        sb_push(SEL_STATE, S_DONE, {pfx, "_s32_state"});
        sb_push(SEL_RUN, 0, {pfx, "_s32_run"});
        sb_push(SEL_DET, 1, {pfx, "_s32_det"});
        sb_push(SEL_CNT, 10, {pfx, "_s32_cnt"});
      end
      if (n == 33) begin
        sb_push(SEL_SYM, 0, {pfx, "_s33_sym"});
        sb_push(SEL_STATE, S_DONE, {pfx, "_s33_state"});
      end
    end
    idle(4);
    checkOutput({pfx, "_done_det"}, int'(detected), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    arm       = 1'b0;
    clear     = 1'b0;
    threshold = '0;
    corr_en   = 1'b0;
    sum_r     = '0;
    sum_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Reset asserted mid-TRACK with three peaks counted.
    arm_run(1000);
    send_mag(2000);
    repeat (15) send_mag(100);
    send_mag(2000);
    repeat (15) send_mag(100);
    send_mag(2000);
    sb_push(SEL_CNT, 3, "t1_cnt3");
    sb_push(SEL_STATE, S_TRACK, "t1_track");
    repeat (3) send_mag(100);
    idle(3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t1_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    send_mag(2000);
    sb_push(SEL_STATE, S_IDLE, "t1_noarm_state");
    sb_push(SEL_CNT, 0, "t1_noarm_cnt");
    sb_push(SEL_RUN, 0, "t1_noarm_run");
    idle(3);

    // Full lock, alignment strobe, then Clear from DONE.
    run_lock_test("t2");
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checkOutput("t2_clear_state", int'(state_dbg), S_IDLE);
    checkOutput("t2_clear_det", int'(detected), 0);
    checkOutput("t2_clear_run", int'(corr_run), 0);

    // Spacing tolerance, window expiry, re-acquire and sidelobe rejection.
    arm_run(1000);
    send_mag(2000);
    sb_push(SEL_CNT, 1, "t3_p1_cnt");
    repeat (15) send_mag(100);
    send_mag(2000);
    sb_push(SEL_CNT, 2, "t3_sp16_cnt");
    repeat (14) send_mag(100);
    send_mag(2000);
    sb_push(SEL_CNT, 3, "t3_sp15_cnt");
    repeat (16) send_mag(100);
    send_mag(2000);
    sb_push(SEL_CNT, 4, "t3_sp17_cnt");
    for (int n = 1; n <= 17; n++) begin
      send_mag(100);
      if (n == 16) begin
        sb_push(SEL_STATE, S_TRACK, "t3_sp16_hold_state");
        sb_push(SEL_CNT, 4, "t3_sp16_hold_cnt");
      end
      if (n == 17) begin
        sb_push(SEL_STATE, S_SEARCH, "t3_expire_state");
        sb_push(SEL_CNT, 0, "t3_expire_cnt");
      end
    end
    send_mag(1200);
    sb_push(SEL_STATE, S_TRACK, "t3_reacq_state");
    sb_push(SEL_CNT, 1, "t3_reacq_cnt");
    sb_push(SEL_MAG, 1200, "t3_reacq_mag");
    repeat (7) send_mag(100);
    send_mag(1500);
    sb_push(SEL_CNT, 1, "t4_side_cnt");
    sb_push(SEL_MAG, 1200, "t4_side_mag");
    sb_push(SEL_STATE, S_TRACK, "t4_side_state");
    repeat (7) send_mag(100);
    send_mag(1100);
    sb_push(SEL_CNT, 2, "t4_after_cnt");
    sb_push(SEL_MAG, 1200, "t4_after_mag");

    // Arm while tracking restarts the search.
    arm_run(1000);
    checkOutput("t6_rearm_state", int'(state_dbg), S_SEARCH);
    checkOutput("t6_rearm_cnt", int'(peak_count), 0);
    checkOutput("t6_rearm_mag", int'(peak_mag), 0);

    // Strict threshold compare and the full-scale negative magnitude.
    arm_run(2000);
    send_mag(2000);
    sb_push(SEL_STATE, S_SEARCH, "thr_equal_state");
    sb_push(SEL_CNT, 0, "thr_equal_cnt");
    send_mag(2001);
    sb_push(SEL_STATE, S_TRACK, "thr_above_state");
    sb_push(SEL_MAG, 2001, "thr_above_mag");
    arm_run(2097151);
    applyStimulus(SUM_W'(21'h100000), SUM_W'(21'h100000));
    sb_push(SEL_STATE, S_TRACK, "fullscale_state");
    sb_push(SEL_MAG, 2097152, "fullscale_mag");

    // Background only: timeout after 4096 valid samples, cleared by Arm.
    arm_run(1000);
    for (int n = 1; n <= 4096; n++) begin
      send_mag(100);
      if (n == 4095) begin
        sb_push(SEL_TO, 0, "t5_4095_to");
        sb_push(SEL_STATE, S_SEARCH, "t5_4095_state");
        sb_push(SEL_RUN, 1, "t5_4095_run");
      end
      if (n == 4096) begin
        sb_push(SEL_TO, 1, "t5_4096_to");
        sb_push(SEL_STATE, S_IDLE, "t5_4096_state");
        sb_push(SEL_RUN, 0, "t5_4096_run");
      end
    end
    arm_run(1000);
    checkOutput("t5_rearm_to", int'(timeout_flag), 0);
    checkOutput("t5_rearm_state", int'(state_dbg), S_SEARCH);

    // Same lock sequence with five idle clocks between valid samples.
    gap = 5;
    run_lock_test("t6");
    gap = 0;

    idle(4);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
